// File: rtl/ps2_scancode_sequencer_pkg.sv
// Shared PS/2 definitions: sequencer FSM states and the special scan-code bytes.
package ps2_scancode_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_CLEAR  = 2'd3
    } seq_state_t;

    localparam logic [7:0] SC_EXTENDED = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_ERR_LOW  = 8'h00;
    localparam logic [7:0] SC_ERR_HIGH = 8'hFF;

endpackage

// File: rtl/ps2_scancode_sequencer.sv
// Drives a PS/2 byte receiver frame by frame and folds E0/F0 prefixes into key events.
module ps2_scancode_sequencer
    import ps2_scancode_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TW             = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_data,
    input  logic [7:0] rx_data,
    input  logic       rx_strb,
    output logic       rx_start,
    output logic       rx_clear,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    output logic       timeout_err,
    output logic       kbd_err
);

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state;
    logic [TW-1:0] timer;
    logic          ext_flag;
    logic          brk_flag;
    logic [7:0]    byte_reg;
    logic          rx_strb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            byte_reg     <= 8'h00;
            rx_strb_q    <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_valid    <= 1'b0;
            rx_start     <= 1'b0;
            rx_clear     <= 1'b0;
            timeout_err  <= 1'b0;
            kbd_err      <= 1'b0;
        end else begin
            rx_strb_q   <= rx_strb;
            rx_start    <= 1'b0;
            rx_clear    <= 1'b0;
            key_valid   <= 1'b0;
            timeout_err <= 1'b0;
            kbd_err     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ps2_clk_posedge && !ps2_data) begin
                        rx_start <= 1'b1;
                        timer    <= '0;
                        state    <= ST_RECV;
                    end
                end

                // A strobe edge wins over a timeout landing in the same cycle.
                ST_RECV: begin
                    timer <= timer + TW'(1);
                    if (rx_strb && !rx_strb_q) begin
                        byte_reg <= rx_data;
                        state    <= ST_ACCEPT;
                    end else if (timer == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        ext_flag    <= 1'b0;
                        brk_flag    <= 1'b0;
                        state       <= ST_CLEAR;
                    end
                end

                ST_ACCEPT: begin
                    case (byte_reg)
                        SC_EXTENDED: ext_flag <= 1'b1;
                        SC_BREAK:    brk_flag <= 1'b1;
                        SC_ERR_LOW, SC_ERR_HIGH: begin
                            kbd_err  <= 1'b1;
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                        default: begin
                            key_code     <= byte_reg;
                            key_extended <= ext_flag;
                            key_release  <= brk_flag;
                            key_valid    <= 1'b1;
                            ext_flag     <= 1'b0;
                            brk_flag     <= 1'b0;
                        end
                    endcase
                    state <= ST_CLEAR;
                end

                ST_CLEAR: begin
                    rx_clear <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Randomised frame-level bench for ps2_scancode_sequencer; the bench plays the byte receiver.
module tb_ps2_scancode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk_posedge = 1'b0;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strb = 1'b0;
    logic       rx_start;
    logic       rx_clear;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_valid;
    logic       timeout_err;
    logic       kbd_err;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: sticky prefixes and the last reported key
    bit       ref_ext = 1'b0;
    bit       ref_brk = 1'b0;
    bit [7:0] last_key = 8'h00;
    bit       last_ext = 1'b0;
    bit       last_rel = 1'b0;
    int       exp_events = 0;
    int       frames_started = 0;

    int key_valid_count = 0;
    int rx_start_count = 0;
    int overlap_count = 0;

    always #5 clk = ~clk;

    ps2_scancode_sequencer #(.TIMEOUT_CYCLES(64), .TW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps2_clk_posedge(ps2_clk_posedge), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_strb(rx_strb),
        .rx_start(rx_start), .rx_clear(rx_clear),
        .key_code(key_code), .key_extended(key_extended), .key_release(key_release),
        .key_valid(key_valid), .timeout_err(timeout_err), .kbd_err(kbd_err)
    );

    always @(negedge clk) begin
        if (key_valid) key_valid_count++;
        if (rx_start) rx_start_count++;
        if (rx_start && rx_clear) overlap_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rx_start"}, rx_start, 0);
        checkOutput({tag, "_rx_clear"}, rx_clear, 0);
        checkOutput({tag, "_key_code"}, key_code, 0);
        checkOutput({tag, "_flags"}, {key_extended, key_release}, 0);
        checkOutput({tag, "_strobes"}, {key_valid, timeout_err, kbd_err}, 0);
    endtask

    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_clk_posedge = 1'($urandom);
            ps2_data = 1'b1;
        end
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
    endtask

    // One complete frame: start bit, optional byte delivery after d cycles, receiver clear.
    task automatic applyStimulus(input logic [7:0] b, input bit do_timeout, input int d, input bit start_in_clear);
        bit exp_valid = 1'b0;
        bit exp_kerr = 1'b0;
        if (do_timeout) begin
            ref_ext = 1'b0; ref_brk = 1'b0;
        end else if (b == 8'hE0) begin
            ref_ext = 1'b1;
        end else if (b == 8'hF0) begin
            ref_brk = 1'b1;
        end else if (b == 8'h00 || b == 8'hFF) begin
            exp_kerr = 1'b1; ref_ext = 1'b0; ref_brk = 1'b0;
        end else begin
            exp_valid = 1'b1;
            last_key = b; last_ext = ref_ext; last_rel = ref_brk;
            ref_ext = 1'b0; ref_brk = 1'b0;
            exp_events++;
        end

        @(negedge clk);
        ps2_clk_posedge = 1'b1;
        ps2_data = 1'b0;
        frames_started++;
        @(posedge clk); #1;
        checkOutput("rx_start", rx_start, 1);

        if (do_timeout) begin
            @(negedge clk);
            ps2_clk_posedge = 1'b0;
            ps2_data = 1'b1;
            repeat (63) @(posedge clk);
            #1 checkOutput("timeout_early", timeout_err, 0);
            @(posedge clk); #1;
            checkOutput("timeout_err", timeout_err, 1);
            checkOutput("timeout_no_valid", key_valid, 0);
            @(posedge clk); #1;
            checkOutput("timeout_rx_clear", rx_clear, 1);
            checkOutput("timeout_err_one_cycle", timeout_err, 0);
        end else begin
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                ps2_clk_posedge = 1'($urandom);
                ps2_data = 1'($urandom);
                @(posedge clk);
            end
            @(negedge clk);
            ps2_clk_posedge = 1'b0;
            ps2_data = 1'b1;
            rx_data = b;
            rx_strb = 1'b1;
            @(posedge clk); #1;
            checkOutput("no_early_valid", key_valid, 0);
            @(posedge clk); #1;
            checkOutput("key_valid", key_valid, exp_valid);
            checkOutput("kbd_err", kbd_err, exp_kerr);
            checkOutput("no_timeout", timeout_err, 0);
            checkOutput("key_code", key_code, last_key);
            checkOutput("key_flags", {key_extended, key_release}, {last_ext, last_rel});
            if (start_in_clear) begin
                @(negedge clk);
                ps2_clk_posedge = 1'b1;
                ps2_data = 1'b0;
            end
            @(posedge clk); #1;
            checkOutput("rx_clear", rx_clear, 1);
            checkOutput("rx_start_vs_clear", rx_start, 0);
            @(negedge clk);
            ps2_clk_posedge = 1'b0;
            ps2_data = 1'b1;
            rx_strb = 1'b0;
            if (start_in_clear) begin
                @(posedge clk); #1;
                checkOutput("start_in_clear_ignored", rx_start, 0);
            end
        end
        @(negedge clk);
        rx_strb = 1'b0;
        ps2_clk_posedge = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idleGap(4);

        applyStimulus(8'h1C, 1'b0, 3, 1'b0);
        idleGap(2);
        applyStimulus(8'hF0, 1'b0, 5, 1'b0);
        applyStimulus(8'h1C, 1'b0, 2, 1'b0);
        applyStimulus(8'hE0, 1'b0, 7, 1'b0);
        applyStimulus(8'hF0, 1'b0, 0, 1'b0);
        applyStimulus(8'h75, 1'b0, 4, 1'b1);
        applyStimulus(8'hE0, 1'b0, 3, 1'b0);
        applyStimulus(8'h00, 1'b1, 0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 6, 1'b0);
        applyStimulus(8'hE0, 1'b0, 3, 1'b0);
        applyStimulus(8'hFF, 1'b0, 9, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1, 1'b0);
        applyStimulus(8'h2A, 1'b0, 63, 1'b0);

        // Reset in the middle of a frame that follows an E0 prefix
        applyStimulus(8'hE0, 1'b0, 2, 1'b0);
        @(negedge clk);
        ps2_clk_posedge = 1'b1;
        ps2_data = 1'b0;
        frames_started++;
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkAllZero("mid_recv_reset");
        ref_ext = 1'b0; ref_brk = 1'b0;
        last_key = 8'h00; last_ext = 1'b0; last_rel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idleGap(3);
        applyStimulus(8'h1C, 1'b0, 4, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r == 2) b = 8'hF0;
            else if (r == 3) b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            else b = 8'($urandom);
            applyStimulus(b, $urandom_range(0, 7) == 0, $urandom_range(0, 40), $urandom_range(0, 3) == 0);
            idleGap($urandom_range(0, 5));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("key_valid_count", key_valid_count, exp_events);
        checkOutput("rx_start_count", rx_start_count, frames_started);
        checkOutput("start_clear_overlap", overlap_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
